// File: rtl/forward_hazard_unit_pkg.sv
// forward_hazard_unit_pkg: operand-mux select encodings and shadow pipeline record types
package forward_hazard_unit_pkg;
    localparam int REG_ADDR_W = 5;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } rec_t;
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
    } wb_rec_t;
endpackage

// File: rtl/forward_hazard_unit_fwd_select.sv
// forward_hazard_unit_fwd_select: newest-producer-first priority compare for one EX operand select
module forward_hazard_unit_fwd_select #(
    parameter int REG_ADDR_W = forward_hazard_unit_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic                  i_ex_valid,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_reg_write,
    input  logic                  i_mem_valid,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    input  logic                  i_mem_reg_write,
    input  logic                  i_kill,
    output logic [1:0]            o_sel
);
    import forward_hazard_unit_pkg::*;
    logic w_ex_hit;
    logic w_mem_hit;
    always_comb begin
        w_ex_hit  = i_ex_valid & i_ex_reg_write & (i_ex_rd != '0) & (i_ex_rd == i_rs);
        w_mem_hit = i_mem_valid & i_mem_reg_write & (i_mem_rd != '0) & (i_mem_rd == i_rs);
        o_sel     = i_kill ? FWD_RF : w_ex_hit ? FWD_MEM : w_mem_hit ? FWD_WB : FWD_RF;
    end
endmodule

// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: registered EX forwarding selects, load-use stall, branch flush and event counters
module forward_hazard_unit #(
    parameter int REG_ADDR_W = forward_hazard_unit_pkg::REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_id_reg_write,
    input  logic                  i_id_mem_read,
    input  logic                  i_branch_taken,
    output logic [1:0]            o_fwd_a,
    output logic [1:0]            o_fwd_b,
    output logic                  o_stall_f,
    output logic                  o_stall_d,
    output logic                  o_flush_d,
    output logic                  o_flush_e,
    output logic [CNT_W-1:0]      o_stall_count,
    output logic [CNT_W-1:0]      o_flush_count
);
    import forward_hazard_unit_pkg::*;
    rec_t       r_ex;
    rec_t       r_mem;
    wb_rec_t    r_wb;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_lu;
    logic       w_kill;
    logic       w_unused;
    assign w_lu      = i_id_valid & r_ex.valid & r_ex.mem_read & (r_ex.rd != '0) &
                       ((r_ex.rd == i_id_rs1) | (r_ex.rd == i_id_rs2));
    assign o_stall_f = w_lu & ~i_branch_taken;
    assign o_stall_d = o_stall_f;
    assign o_flush_d = i_branch_taken;
    assign o_flush_e = i_branch_taken | w_lu;
    assign w_kill    = o_flush_e | ~i_id_valid;
    // WB record and MEM load flag track the datapath but feed no decision here
    assign w_unused  = ^{r_wb, r_mem.mem_read};
    forward_hazard_unit_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel_a (
        .i_rs(i_id_rs1),
        .i_ex_valid(r_ex.valid),
        .i_ex_rd(r_ex.rd),
        .i_ex_reg_write(r_ex.reg_write),
        .i_mem_valid(r_mem.valid),
        .i_mem_rd(r_mem.rd),
        .i_mem_reg_write(r_mem.reg_write),
        .i_kill(w_kill),
        .o_sel(w_fwd_a)
    );
    forward_hazard_unit_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel_b (
        .i_rs(i_id_rs2),
        .i_ex_valid(r_ex.valid),
        .i_ex_rd(r_ex.rd),
        .i_ex_reg_write(r_ex.reg_write),
        .i_mem_valid(r_mem.valid),
        .i_mem_rd(r_mem.rd),
        .i_mem_reg_write(r_mem.reg_write),
        .i_kill(w_kill),
        .o_sel(w_fwd_b)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex          <= rec_t'('0);
            r_mem         <= rec_t'('0);
            r_wb          <= wb_rec_t'('0);
            o_fwd_a       <= FWD_RF;
            o_fwd_b       <= FWD_RF;
            o_stall_count <= '0;
            o_flush_count <= '0;
        end else begin
            r_wb    <= wb_rec_t'{r_mem.valid, r_mem.rd, r_mem.reg_write};
            r_mem   <= r_ex;
            r_ex    <= o_flush_e ? rec_t'('0) : rec_t'{i_id_valid, i_id_rd, i_id_reg_write, i_id_mem_read};
            o_fwd_a <= w_fwd_a;
            o_fwd_b <= w_fwd_b;
            if (o_stall_d && !(&o_stall_count))
                o_stall_count <= o_stall_count + CNT_W'(1);
            if (i_branch_taken && !(&o_flush_count))
                o_flush_count <= o_flush_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb_forward_hazard_unit: directed vectors, per-cycle model compare and literal pins
module tb_forward_hazard_unit;
    logic       clk;
    logic       rst;
    logic       i_id_valid;
    logic [4:0] i_id_rs1;
    logic [4:0] i_id_rs2;
    logic [4:0] i_id_rd;
    logic       i_id_reg_write;
    logic       i_id_mem_read;
    logic       i_branch_taken;
    logic [1:0]  o_fwd_a, o_fwd_b, a3_fwd_a, a3_fwd_b;
    logic        o_stall_f, o_stall_d, o_flush_d, o_flush_e;
    logic        a3_stall_f, a3_stall_d, a3_flush_d, a3_flush_e;
    logic [31:0] o_stall_count, o_flush_count;
    logic [2:0]  a3_stall_count, a3_flush_count;
    int errs = 0;
    int checks = 0;
    forward_hazard_unit dut (
        .clk(clk), .rst(rst),
        .i_id_valid(i_id_valid), .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2), .i_id_rd(i_id_rd),
        .i_id_reg_write(i_id_reg_write), .i_id_mem_read(i_id_mem_read), .i_branch_taken(i_branch_taken),
        .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b),
        .o_stall_f(o_stall_f), .o_stall_d(o_stall_d), .o_flush_d(o_flush_d), .o_flush_e(o_flush_e),
        .o_stall_count(o_stall_count), .o_flush_count(o_flush_count)
    );
    forward_hazard_unit #(.CNT_W(3)) dut3 (
        .clk(clk), .rst(rst),
        .i_id_valid(i_id_valid), .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2), .i_id_rd(i_id_rd),
        .i_id_reg_write(i_id_reg_write), .i_id_mem_read(i_id_mem_read), .i_branch_taken(i_branch_taken),
        .o_fwd_a(a3_fwd_a), .o_fwd_b(a3_fwd_b),
        .o_stall_f(a3_stall_f), .o_stall_d(a3_stall_d), .o_flush_d(a3_flush_d), .o_flush_e(a3_flush_e),
        .o_stall_count(a3_stall_count), .o_flush_count(a3_flush_count)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // model: the instructions occupying EX (slot 0) and MEM (slot 1)
    typedef struct packed { logic v; logic [4:0] rd; logic wr; logic ld; } ins_t;
    ins_t   pipe [2];
    int     m_fa, m_fb;
    longint m_sc, m_fc, m_sc3, m_fc3;
    function automatic bit m_lu();
        return i_id_valid && pipe[0].v && pipe[0].ld && pipe[0].rd != 5'd0 &&
               (pipe[0].rd == i_id_rs1 || pipe[0].rd == i_id_rs2);
    endfunction
    function automatic int m_sel(input logic [4:0] rs);
        if (!i_id_valid || i_branch_taken || m_lu()) return 0;
        for (int d = 0; d < 2; d++)
            if (pipe[d].v && pipe[d].wr && pipe[d].rd != 5'd0 && pipe[d].rd == rs) return 2 - d;
        return 0;
    endfunction
    function automatic longint sat(input longint x, input longint mx);
        return (x + 1 > mx) ? mx : x + 1;
    endfunction
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe[0] <= '0;
            pipe[1] <= '0;
            m_fa <= 0; m_fb <= 0;
            m_sc <= 0; m_fc <= 0; m_sc3 <= 0; m_fc3 <= 0;
        end else begin
            m_fa <= m_sel(i_id_rs1);
            m_fb <= m_sel(i_id_rs2);
            if (m_lu() && !i_branch_taken) begin
                m_sc  <= sat(m_sc, 64'hFFFF_FFFF);
                m_sc3 <= sat(m_sc3, 7);
            end
            if (i_branch_taken) begin
                m_fc  <= sat(m_fc, 64'hFFFF_FFFF);
                m_fc3 <= sat(m_fc3, 7);
            end
            pipe[1] <= pipe[0];
            pipe[0] <= (i_branch_taken || m_lu()) ? '0 : ins_t'{i_id_valid, i_id_rd, i_id_reg_write, i_id_mem_read};
        end
    end
    task automatic chk(input string n, input logic [63:0] got, input longint exp);
        checks++;
        if (got !== 64'(exp)) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d at %0t", n, got, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (!rst) begin
            chk("fwd_a", 64'(o_fwd_a), m_fa);
            chk("fwd_b", 64'(o_fwd_b), m_fb);
            chk("stall_f", 64'(o_stall_f), m_lu() && !i_branch_taken);
            chk("stall_d", 64'(o_stall_d), m_lu() && !i_branch_taken);
            chk("flush_d", 64'(o_flush_d), i_branch_taken);
            chk("flush_e", 64'(o_flush_e), i_branch_taken || m_lu());
            chk("stall_count", 64'(o_stall_count), m_sc);
            chk("flush_count", 64'(o_flush_count), m_fc);
            chk("w3_fwd", 64'({a3_fwd_a, a3_fwd_b}), m_fa * 4 + m_fb);
            chk("w3_ctl", 64'({a3_stall_f, a3_stall_d, a3_flush_d, a3_flush_e}),
                64'({o_stall_f, o_stall_d, o_flush_d, o_flush_e}));
            chk("w3_stall_count", 64'(a3_stall_count), m_sc3);
            chk("w3_flush_count", 64'(a3_flush_count), m_fc3);
        end
    end
    task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic wr, input logic ld, input logic br);
        @(posedge clk);
        #1;
        i_id_valid = v; i_id_rs1 = rs1; i_id_rs2 = rs2; i_id_rd = rd;
        i_id_reg_write = wr; i_id_mem_read = ld; i_branch_taken = br;
        #1;
    endtask
    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic chk_zero(input string n);
        chk({n, "_fwd"}, 64'({o_fwd_a, o_fwd_b}), 0);
        chk({n, "_ctl"}, 64'({o_stall_f, o_stall_d, o_flush_d, o_flush_e}), 0);
        chk({n, "_stall_count"}, 64'(o_stall_count), 0);
        chk({n, "_flush_count"}, 64'(o_flush_count), 0);
        chk({n, "_w3_flush_count"}, 64'(a3_flush_count), 0);
    endtask
    initial begin
        rst = 1'b1;
        i_id_valid = 0; i_id_rs1 = 0; i_id_rs2 = 0; i_id_rd = 0;
        i_id_reg_write = 0; i_id_mem_read = 0; i_branch_taken = 0;
        #12;
        chk_zero("reset");
        #11;
        rst = 1'b0;
        nop();
        chk_zero("post_reset");
        // back-to-back: add x5 ; sub x6,x5,x7
        step(1, 1, 2, 5, 1, 0, 0);
        step(1, 5, 7, 6, 1, 0, 0);
        chk("b2b_stall_d", 64'(o_stall_d), 0);
        nop();
        chk("b2b_fwd_a", 64'(o_fwd_a), 2);
        chk("b2b_fwd_b", 64'(o_fwd_b), 0);
        nop(); nop();
        // distance 2: add x5 ; unrelated ; or x8,x1,x5
        step(1, 1, 2, 5, 1, 0, 0);
        step(1, 3, 4, 11, 1, 0, 0);
        step(1, 1, 5, 8, 1, 0, 0);
        nop();
        chk("d2_fwd_b", 64'(o_fwd_b), 1);
        chk("d2_fwd_a", 64'(o_fwd_a), 0);
        nop(); nop();
        // EX and MEM both write x5: newest wins
        step(1, 1, 2, 5, 1, 0, 0);
        step(1, 3, 4, 5, 1, 0, 0);
        step(1, 1, 5, 8, 1, 0, 0);
        nop();
        chk("prio_fwd_b", 64'(o_fwd_b), 2);
        nop(); nop();
        // load-use: lw x9 ; add x10,x9,x9 (re-presented after the stall)
        step(1, 1, 0, 9, 1, 1, 0);
        step(1, 9, 9, 10, 1, 0, 0);
        chk("lu_stall_f", 64'(o_stall_f), 1);
        chk("lu_stall_d", 64'(o_stall_d), 1);
        chk("lu_flush_e", 64'(o_flush_e), 1);
        chk("lu_flush_d", 64'(o_flush_d), 0);
        chk("lu_count_before", 64'(o_stall_count), 0);
        step(1, 9, 9, 10, 1, 0, 0);
        chk("lu_one_cycle", 64'(o_stall_d), 0);
        chk("lu_count_after", 64'(o_stall_count), 1);
        nop();
        chk("lu_fwd_a", 64'(o_fwd_a), 1);
        chk("lu_fwd_b", 64'(o_fwd_b), 1);
        nop(); nop();
        // x0 guard: ALU producer and load producer with rd=0
        step(1, 1, 2, 0, 1, 0, 0);
        step(1, 0, 0, 3, 1, 0, 0);
        chk("x0_stall_d", 64'(o_stall_d), 0);
        nop();
        chk("x0_fwd", 64'({o_fwd_a, o_fwd_b}), 0);
        step(1, 1, 0, 0, 1, 1, 0);
        step(1, 0, 0, 4, 1, 0, 0);
        chk("x0_ld_stall_d", 64'(o_stall_d), 0);
        chk("x0_ld_flush_e", 64'(o_flush_e), 0);
        nop();
        chk("x0_ld_fwd_a", 64'(o_fwd_a), 0);
        nop(); nop();
        // taken branch in the same cycle as a load-use
        step(1, 1, 0, 9, 1, 1, 0);
        step(1, 9, 9, 10, 1, 0, 1);
        chk("br_flush_d", 64'(o_flush_d), 1);
        chk("br_flush_e", 64'(o_flush_e), 1);
        chk("br_stall_d", 64'(o_stall_d), 0);
        chk("br_flush_before", 64'(o_flush_count), 0);
        nop();
        chk("br_flush_after", 64'(o_flush_count), 1);
        chk("br_stall_same", 64'(o_stall_count), 1);
        chk("br_fwd", 64'({o_fwd_a, o_fwd_b}), 0);
        nop();
        // nine more flushes: 3-bit counter pins at 7
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 0, 1);
        nop();
        chk("sat_w3_flush", 64'(a3_flush_count), 7);
        chk("sat_w32_flush", 64'(o_flush_count), 10);
        chk("sat_w3_stall", 64'(a3_stall_count), 1);
        // asynchronous reset mid-stream with a live select and a live stall
        step(1, 1, 2, 5, 1, 0, 0);
        step(1, 5, 0, 9, 1, 1, 0);
        step(1, 9, 3, 12, 1, 0, 0);
        chk("pre_rst_fwd_a", 64'(o_fwd_a), 2);
        chk("pre_rst_stall_d", 64'(o_stall_d), 1);
        #1;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #2;
        rst = 1'b0;
        nop();
        chk_zero("after_async_rst");
        step(1, 1, 2, 5, 1, 0, 0);
        step(1, 5, 5, 6, 1, 0, 0);
        nop();
        chk("recover_fwd", 64'({o_fwd_a, o_fwd_b}), 10);
        nop();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/forward_hazard_unit.md
Name: forward_hazard_unit

Overview:
- Pipeline-control block that drives the 2-bit select inputs of the two EX-stage operand 3:1 multiplexers. It also generates the stall and flush controls for the 5-stage core.
- Keeps its own shadow copy of the EX/MEM/WB destination-register information and advances it in lock-step with the datapath pipeline registers.
- Computes forwarding selects one cycle early, at ID, and registers them so they are stable at the start of EX.
- Detects load-use hazards and taken-branch flushes, and keeps saturating event counters for performance debug.

Parameters:
- REG_ADDR_W, 5, register-index width.
- CNT_W, 32, width of the stall and flush event counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rs1  in  REG_ADDR_W  source register 1 of the ID instruction.
- id_rs2  in  REG_ADDR_W  source register 2 of the ID instruction.
- id_rd  in  REG_ADDR_W  destination register of the ID instruction.
- id_reg_write  in  1  the ID instruction writes the register file.
- id_mem_read  in  1  the ID instruction is a load.
- branch_taken  in  1  a branch or jump resolved taken in EX this cycle.
- fwd_a  out  2  select for the EX operand-A mux (registered).
- fwd_b  out  2  select for the EX operand-B mux (registered).
- stall_f  out  1  hold the PC (combinational).
- stall_d  out  1  hold the IF/ID register (combinational).
- flush_d  out  1  clear the IF/ID register (combinational).
- flush_e  out  1  clear the ID/EX register (combinational).
- stall_count  out  CNT_W  load-use stall cycles, saturating.
- flush_count  out  CNT_W  taken-branch flushes, saturating.

Behaviour:
- Select encodings, matching the operand-mux inputs:
  - 2'b00 = register-file value.
  - 2'b01 = WB result.
  - 2'b10 = MEM ALU result.
  - 2'b11 is never driven.
- Shadow records, each holding {valid, rd, reg_write, mem_read}:
  - EX record: one per instruction currently in EX.
  - MEM record: as for EX.
  - WB record: {valid, rd, reg_write} only.
- Reset (asynchronous, rst=1): all records invalid with fields zero; fwd_a=fwd_b=2'b00; both counters 0. All combinational outputs are therefore 0 while rst=1 and in the first cycle after reset.
- Load-use hazard (lu), combinational:
  - lu = id_valid & EX.valid & EX.mem_read & EX.rd!=0 & (EX.rd==id_rs1 | EX.rd==id_rs2).
- Control outputs:
  - stall_f = stall_d = lu & ~branch_taken. A taken branch wins, because the ID instruction is discarded anyway.
  - flush_d = branch_taken.
  - flush_e = branch_taken | lu.
- Record advance, every cycle. There is no global enable; the pipeline never freezes EX/MEM/WB.
  - WB <= MEM.
  - MEM <= EX.
  - If flush_e: EX <= bubble (valid=0). Otherwise EX <= {id_valid, id_rd, id_reg_write, id_mem_read}.
- Forwarding-select next-state, evaluated for each source (rs = id_rs1 gives fwd_a, id_rs2 gives fwd_b):
  - If flush_e or ~id_valid: 2'b00.
  - Else if EX.valid & EX.reg_write & EX.rd!=0 & EX.rd==rs: 2'b10, since that instruction will be in MEM next cycle.
  - Else if MEM.valid & MEM.reg_write & MEM.rd!=0 & MEM.rd==rs: 2'b01, since that instruction will be in WB next cycle.
  - Else 2'b00.
  - Newest producer has priority.
- Latency: the selects are registered with 1-cycle latency, valid for the whole cycle the instruction occupies EX.
- x0: a source or destination index of 0 never forwards and never stalls.
- Load after stall: the load is in MEM when the stalled instruction re-evaluates, so the select resolves to 2'b01.
- WB-to-ID same-cycle read: a producer writing back in the same cycle that ID reads the register is covered by the register file's write-first behaviour, not by this block.
- Simultaneous branch_taken and lu: flush only. No stall, and stall_count does not increment.
- Counters:
  - stall_count increments on each cycle with stall_d=1.
  - flush_count increments on each cycle with branch_taken=1.
  - Both saturate at all-ones.
- Reset asserted mid-stream immediately clears all records, selects and counters. There is no partial recovery.

Decomposition:
- Shared package contents:
  - Constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - The shadow-record typedef.
  - REG_ADDR_W default.
- One natural sub-module: fwd_select. It is the combinational priority comparator (rs, EX record, MEM record, kill) producing a 2-bit select, instantiated twice for operands A and B.

Test Plan:
1. Back-to-back dependency.
   - Stimulus: "add x5" then "sub x6,x5,x7".
   - Required: on the cycle sub is in EX, fwd_a=2'b10 and fwd_b=2'b00; stall_d=0.
2. Distance-2 dependency.
   - Stimulus: "add x5", an unrelated instruction, then "or x8,x1,x5".
   - Required: fwd_b=2'b01.
   - Stimulus: with both EX and MEM writing x5.
   - Required: fwd_b=2'b10 (priority).
3. Load-use.
   - Stimulus: "lw x9" then "add x10,x9,x9".
   - Required: exactly one cycle with stall_f=stall_d=flush_e=1; stall_count goes 0→1; add then reaches EX with fwd_a=fwd_b=2'b01.
4. x0 guard.
   - Stimulus: producer with rd=0 followed by a consumer of x0, including a load with rd=0.
   - Required: fwd=2'b00, no stall.
5. Branch vs hazard.
   - Stimulus: branch_taken=1 in the same cycle lu would be 1.
   - Required: flush_d=flush_e=1, stall_d=0; flush_count +1, stall_count unchanged; the next EX select is 2'b00.
6. Reset and saturation.
   - Stimulus: assert rst mid-stream, asynchronously.
   - Required: all outputs and counters read 0 before the next clk edge.
   - Stimulus: preload behaviour with CNT_W=3 and 9 flushes.
   - Required: flush_count=7.
